// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU with pipeline stall
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             annul_i,
    output logic             stall_div,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    typedef enum logic [1:0] {IDLE, PREP, BUSY, DONE} state_t;
    state_t state, nextState;
    logic [WIDTH-1:0] aReg, bReg, remReg, newRem, newQuo, absA, absB;
    logic [WIDTH:0] remSh, trial;
    logic [CNT_W-1:0] cnt;
    logic signedReg, signQ, signR, lastStep;
    assign absA = (signedReg && aReg[WIDTH-1]) ? -aReg : aReg;
    assign absB = (signedReg && bReg[WIDTH-1]) ? -bReg : bReg;
    assign remSh = {remReg, aReg[WIDTH-1]};
    assign trial = remSh - {1'b0, bReg};
    assign newRem = trial[WIDTH] ? remSh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign newQuo = {aReg[WIDTH-2:0], ~trial[WIDTH]};
    assign lastStep = cnt == CNT_W'(WIDTH - 1);
    // state register; a flush or reset drops any divide in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nextState;
    end
    // next-state, stall and ready; annul overrides everything
    always_comb begin
        nextState = state;
        stall_div = 1'b0;
        ready_o = 1'b0;
        case (state)
            IDLE: begin
                stall_div = start_i;
                nextState = start_i ? PREP : IDLE;
            end
            PREP: begin
                stall_div = 1'b1;
                nextState = (bReg == '0) ? DONE : BUSY;
            end
            BUSY: begin
                stall_div = 1'b1;
                nextState = lastStep ? DONE : BUSY;
            end
            DONE: begin
                ready_o = 1'b1;
                nextState = IDLE;
            end
        endcase
        if (annul_i) begin
            nextState = IDLE;
            stall_div = 1'b0;
            ready_o = 1'b0;
        end
    end
    // datapath: latch operands, take magnitudes, iterate, write sign-fixed results on DONE entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aReg <= '0;
            bReg <= '0;
            remReg <= '0;
            cnt <= '0;
            signedReg <= 1'b0;
            signQ <= 1'b0;
            signR <= 1'b0;
            hi_o <= '0;
            lo_o <= '0;
        end else if (!annul_i) begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        aReg <= a_i;
                        bReg <= b_i;
                        signedReg <= signed_i;
                    end
                end
                PREP: begin
                    aReg <= absA;
                    bReg <= absB;
                    remReg <= '0;
                    cnt <= '0;
                    signQ <= signedReg && (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
                    signR <= signedReg && aReg[WIDTH-1];
                    if (bReg == '0) begin
                        lo_o <= '1;
                        hi_o <= aReg;
                    end
                end
                BUSY: begin
                    remReg <= newRem;
                    aReg <= newQuo;
                    cnt <= cnt + CNT_W'(1);
                    if (lastStep) begin
                        lo_o <= signQ ? -newQuo : newQuo;
                        hi_o <= signR ? -newRem : newRem;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed divide vectors
module tb_div_unit;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst, start_i, signed_i, annul_i;
    logic [W-1:0] a_i, b_i;
    logic stall_div, ready_o;
    logic [W-1:0] hi_o, lo_o;
    logic [63:0] expQ[$];
    logic [W-1:0] lastHi = '0, lastLo = '0;
    int checks = 0, failures = 0;

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .a_i(a_i), .b_i(b_i), .annul_i(annul_i), .stall_div(stall_div),
        .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (ready_o) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready: got ready_o=1 expected no result at %0t", $time);
                end else begin
                    e = expQ.pop_front();
                    check("result_hi", hi_o, e[63:32]);
                    check("result_lo", lo_o, e[31:0]);
                end
            end
        end
    endtask

    task automatic doDiv(input string name, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] lo, input logic [W-1:0] hi, input int lat, input bit hold);
        int cyc = 0;
        int stalls = 0;
        expQ.push_back({hi, lo});
        lastHi = hi;
        lastLo = lo;
        @(negedge clk);
        start_i = 1'b1;
        signed_i = s;
        a_i = a;
        b_i = b;
        #1;
        while (!ready_o && cyc < 100) begin
            stalls += int'(stall_div);
            @(negedge clk);
            #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, lat);
        check({name, "_stall_cycles"}, stalls, lat);
        check({name, "_stall_at_ready"}, stall_div, 0);
        if (!hold) begin
            start_i = 1'b0;
            @(negedge clk);
            #1;
            check({name, "_ready_pulse"}, ready_o, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        signed_i = 1'b0;
        annul_i = 1'b0;
        a_i = '0;
        b_i = '0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        #1;
        check("reset_hi", hi_o, 0);
        check("reset_lo", lo_o, 0);
        check("reset_ready", ready_o, 0);
        check("reset_stall", stall_div, 0);
        @(negedge clk);
        rst = 1'b0;
        doDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b0);
        doDiv("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, 1'b0);
        doDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 34, 1'b0);
        doDiv("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 34, 1'b0);
        doDiv("divu_big", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 34, 1'b0);
        doDiv("divu_by0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 2, 1'b0);
        doDiv("div_by0_neg", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 2, 1'b0);
        doDiv("div_zero_dividend", 1'b1, 32'd0, 32'd3, 32'd0, 32'd0, 34, 1'b0);
        doDiv("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 34, 1'b0);
        doDiv("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 34, 1'b0);
        doDiv("b2b_first", 1'b1, 32'd1000, 32'hFFFFFFDF, 32'hFFFFFFE2, 32'd10, 34, 1'b1);
        doDiv("b2b_second", 1'b0, 32'd12345, 32'd100, 32'd123, 32'd45, 34, 1'b0);
        @(negedge clk);
        start_i = 1'b1;
        signed_i = 1'b0;
        a_i = 32'd1000;
        b_i = 32'd3;
        repeat (12) @(negedge clk);
        annul_i = 1'b1;
        #1;
        check("annul_busy_stall", stall_div, 0);
        check("annul_busy_ready", ready_o, 0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("annul_hold_hi", hi_o, lastHi);
        check("annul_hold_lo", lo_o, lastLo);
        @(negedge clk);
        start_i = 1'b1;
        annul_i = 1'b1;
        #1;
        check("annul_idle_stall", stall_div, 0);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (40) @(negedge clk);
        @(negedge clk);
        start_i = 1'b1;
        signed_i = 1'b1;
        a_i = 32'd77;
        b_i = 32'd5;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        start_i = 1'b0;
        #1;
        check("midrst_hi", hi_o, 0);
        check("midrst_lo", lo_o, 0);
        check("midrst_stall", stall_div, 0);
        check("midrst_ready", ready_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        doDiv("after_rst", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 34, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
